// File: rtl/serpent_dec_iter.sv
// Iterative Serpent-128 decryption core: RPC inverse rounds per clock, reused over 32/RPC cycles.
// Latency: out_valid first high 32/RPC cycles after the accept edge; one block per 32/RPC + 2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (no same-cycle turnaround).
module serpent_dec_iter #(
    parameter int RPC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_data,
    output logic [5:0]         rk_idx,
    input  logic [128*RPC-1:0] rk_data,
    input  logic [127:0]       rk_last,
    output logic               busy
);

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
        $error("serpent_dec_iter: RPC must be 1, 2, 4 or 8");
    end

    // Inverse S-boxes, nibble n of entry b holds invS_b(n).
    localparam logic [63:0] INV_SBOX [8] = '{
        64'h289F74E1C56A0B3D,
        64'h0AD1974B3C6FE285,
        64'h7A85D63021EB4F9C,
        64'h1F842C53D6EB7A90,
        64'h1DF46BC2E79A3805,
        64'h0AC7356BED1492F8,
        64'hB8C27E940635D1AF,
        64'h241A7BC58FE9D603
    };

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [5:0]   r_q;
    logic [127:0] s_q;
    logic [127:0] round_out;
    logic         last_cycle;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [127:0] inv_lt(input logic [127:0] v);
        logic [31:0] x0, x1, x2, x3;
        {x3, x2, x1, x0} = v;
        x2 = ror32(x2, 22);
        x0 = ror32(x0, 5);
        x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = x0 ^ x1 ^ x3;
        x3 = ror32(x3, 7);
        x1 = ror32(x1, 1);
        x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = x1 ^ x0 ^ x2;
        x2 = ror32(x2, 3);
        x0 = ror32(x0, 13);
        return {x3, x2, x1, x0};
    endfunction

    // Bitsliced: bit i of words x3..x0 forms one nibble through the selected box.
    function automatic logic [127:0] inv_sbox_layer(input logic [2:0] box, input logic [127:0] v);
        logic [63:0]  tbl;
        logic [3:0]   nib;
        logic [3:0]   o;
        logic [127:0] res;
        tbl = INV_SBOX[box];
        res = '0;
        for (int i = 0; i < 32; i++) begin
            nib = {v[96+i], v[64+i], v[32+i], v[i]};
            o   = tbl[{nib, 2'b00} +: 4];
            res[i]    = o[0];
            res[32+i] = o[1];
            res[64+i] = o[2];
            res[96+i] = o[3];
        end
        return res;
    endfunction

    // Slice j handles round k = r - j; only slice 0 of the first cycle sees k = 31,
    // which replaces the linear transform with the whitening XOR of K32.
    for (genvar j = 0; j < RPC; j++) begin : g_round
        logic [5:0]   k;
        logic [127:0] din;
        logic [127:0] pre;
        logic [127:0] dout;
        if (j == 0) begin : g_first
            assign din = s_q;
        end else begin : g_chain
            assign din = g_round[j-1].dout;
        end
        assign k    = r_q - 6'(j);
        assign pre  = (k == 6'd31) ? (din ^ rk_last) : inv_lt(din);
        assign dout = inv_sbox_layer(k[2:0], pre) ^ rk_data[128*j +: 128];
    end

    assign round_out  = g_round[RPC-1].dout;
    assign last_cycle = (r_q == 6'(RPC - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the accept / iterate / hand-off sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last_cycle) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Block state and round counter: load on accept, advance RPC rounds per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 6'd31;
            s_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) s_q <= in_data;
                ST_RUN: begin
                    s_q <= round_out;
                    if (!last_cycle) r_q <= r_q - 6'(RPC);
                end
                ST_DONE: if (out_ready) r_q <= 6'd31;
                default: r_q <= 6'd31;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_RUN);
    assign out_valid = (state == ST_DONE);
    assign out_data  = s_q;
    assign rk_idx    = r_q;

endmodule

// File: tb/tb_serpent_dec_iter.sv
// Bench for serpent_dec_iter: four instances (RPC 1,2,4,8) share stimulus and a key table.
// Each instance has a monitor comparing against a behavioural decryption model.
// Main sequence: reset, vector table, random golden, backpressure, mid-run reset, streaming.
module tb_serpent_dec_iter;

    localparam int NI = 4;

    localparam int FWD [8][16] = '{
        '{ 3, 8,15, 1,10, 6, 5,11,14,13, 4, 2, 7, 0, 9,12},
        '{15,12, 2, 7, 9, 0, 5,10, 1,11,14, 8, 6,13, 3, 4},
        '{ 8, 6, 7, 9, 3,12,10,15,13, 1,14, 4, 0,11, 5, 2},
        '{ 0,15,11, 8,12, 9, 6, 3,13, 1, 2, 4,10, 7, 5,14},
        '{ 1,15, 8, 3,12, 0,11, 6, 2, 5, 4,10, 9,14, 7,13},
        '{15, 5, 2,11, 4,10, 9,12, 0, 3,14, 8,13, 6, 7, 1},
        '{ 7, 2,12, 5, 8, 4, 6,11,14, 9, 1,15,13, 3,10, 0},
        '{ 1,13,15, 0,14, 8, 2,11, 7, 4,12,10, 9, 3, 5, 6}
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid;
    logic          out_ready;
    logic [127:0]  in_data;
    logic [NI-1:0] in_ready;
    logic [NI-1:0] out_valid;
    logic [NI-1:0] busy;
    logic [127:0]  out_data [NI];
    logic [5:0]    rk_idx [NI];
    logic [127:0]  K [64];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit stream_on = 1'b0;
    int stream_start = 0;
    int acc_cnt [NI];
    logic [127:0] exp_q [NI][$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [127:0] sb_inv(input int b, input logic [127:0] v);
        logic [31:0] w [4];
        logic [31:0] o [4];
        int nib;
        for (int j = 0; j < 4; j++) begin
            w[j] = v[32*j +: 32];
            o[j] = '0;
        end
        for (int i = 0; i < 32; i++) begin
            nib = 8*int'(w[3][i]) + 4*int'(w[2][i]) + 2*int'(w[1][i]) + int'(w[0][i]);
            for (int x = 0; x < 16; x++)
                if (FWD[b][x] == nib)
                    for (int j = 0; j < 4; j++) o[j][i] = ((x >> j) & 1) != 0;
        end
        return {o[3], o[2], o[1], o[0]};
    endfunction

    function automatic logic [127:0] lt_inv(input logic [127:0] v);
        logic [31:0] x [4];
        for (int j = 0; j < 4; j++) x[j] = v[32*j +: 32];
        x[2] = ror(x[2], 22);                 x[0] = ror(x[0], 5);
        x[2] = x[2] ^ x[3] ^ (x[1] << 7);     x[0] = x[0] ^ x[1] ^ x[3];
        x[3] = ror(x[3], 7);                  x[1] = ror(x[1], 1);
        x[3] = x[3] ^ x[2] ^ (x[0] << 3);     x[1] = x[1] ^ x[0] ^ x[2];
        x[2] = ror(x[2], 3);                  x[0] = ror(x[0], 13);
        return {x[3], x[2], x[1], x[0]};
    endfunction

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
        logic [127:0] s;
        s = sb_inv(7, ct ^ K[32]) ^ K[31];
        for (int k = 30; k >= 0; k--) s = sb_inv(k % 8, lt_inv(s)) ^ K[k];
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_keys(input int mode);
        logic [31:0] t;
        for (int i = 0; i < 64; i++) K[i] = '0;
        for (int i = 0; i <= 32; i++) begin
            t = 32'h9E3779B9 * 32'(i + 1);
            case (mode)
                0: K[i] = '0;
                1: K[i] = {t, ~t, t ^ 32'h5A5A5A5A, t + 32'd7};
                2: K[i] = {32'(i), 32'(i * 3), 32'hFFFF0000 ^ 32'(i), 32'(i * i)};
                default: K[i] = rand128();
            endcase
        end
    endtask

    // ---------------- DUTs, key stores, monitors ----------------
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int R   = 1 << g;
        localparam int LAT = 32 / R;
        logic [128*R-1:0] rkd;
        for (genvar j = 0; j < R; j++) begin : g_key
            assign rkd[128*j +: 128] = K[rk_idx[g] - 6'(j)];
        end

        serpent_dec_iter #(.RPC(R)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .in_data   (in_data),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .out_data  (out_data[g]),
            .rk_idx    (rk_idx[g]),
            .rk_data   (rkd),
            .rk_last   (K[32]),
            .busy      (busy[g])
        );

        int acc = 0;
        int last_acc = -1;
        bit prev_ov = 1'b0;
        logic [127:0] prev_dat = '0;

        always @(negedge clk) begin
            if (rst) begin
                exp_q[g].delete();
                prev_ov = 1'b0;
            end else begin
                if (busy[g])
                    chk($sformatf("rk_idx[R%0d]", R), 128'(rk_idx[g]), 128'(31 - R * (cyc - acc)));
                if (out_valid[g]) begin
                    if (!prev_ov) chk($sformatf("latency[R%0d]", R), 128'(cyc - acc), 128'(LAT));
                    else          chk($sformatf("hold[R%0d]", R), out_data[g], prev_dat);
                    if (out_ready) begin
                        if (exp_q[g].size() == 0) chk($sformatf("spurious_out[R%0d]", R), 128'(1), 128'(0));
                        else chk($sformatf("plaintext[R%0d]", R), out_data[g], exp_q[g].pop_front());
                    end
                end
                if (in_ready[g]) begin
                    chk($sformatf("idle_flags[R%0d]", R), 128'({busy[g], out_valid[g]}), 128'(0));
                    if (in_valid) begin
                        exp_q[g].push_back(ref_decrypt(in_data));
                        if (stream_on && last_acc >= stream_start)
                            chk($sformatf("stream_gap[R%0d]", R), 128'(cyc + 1 - last_acc), 128'(LAT + 2));
                        last_acc = cyc + 1;
                        acc = cyc + 1;
                        acc_cnt[g]++;
                    end
                end
                prev_ov  = out_valid[g];
                prev_dat = out_data[g];
            end
        end
    end

    // ---------------- sequencing helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(&in_ready) && n < budget) begin
            tick();
            n++;
        end
        if (!(&in_ready)) chk("idle_timeout", 128'(in_ready), 128'({NI{1'b1}}));
    endtask

    task automatic wait_all_ov(input int budget);
        int n = 0;
        while (!(&out_valid) && n < budget) begin
            tick();
            n++;
        end
        if (!(&out_valid)) chk("out_valid_timeout", 128'(out_valid), 128'({NI{1'b1}}));
    endtask

    task automatic send(input logic [127:0] ct);
        wait_idle(200);
        in_valid = 1'b1;
        in_data  = ct;
        tick();
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [127:0] ct;
        int           kmode;
        logic [127:0] pt;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt [6];
        int   base;
        int   n;
        bit   any_ov;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        for (int g = 0; g < NI; g++) acc_cnt[g] = 0;
        set_keys(0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk("rst_in_ready",  128'(in_ready[g]),  128'(1));
            chk("rst_out_valid", 128'(out_valid[g]), 128'(0));
            chk("rst_busy",      128'(busy[g]),      128'(0));
            chk("rst_out_data",  out_data[g],        128'(0));
            chk("rst_rk_idx",    128'(rk_idx[g]),    128'(31));
        end
        tick();

        // Vector table: plaintexts identical across all RPC values
        vt[0] = '{128'h0, 0, '0};
        vt[1] = '{{4{32'hFFFFFFFF}}, 0, '0};
        vt[2] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 1, '0};
        vt[3] = '{128'h1, 1, '0};
        vt[4] = '{128'h80000000_00000000_00000000_00000000, 2, '0};
        vt[5] = '{128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 2, '0};
        for (int i = 0; i < 6; i++) begin
            set_keys(vt[i].kmode);
            vt[i].pt = ref_decrypt(vt[i].ct);
        end
        for (int i = 0; i < 6; i++) begin
            set_keys(vt[i].kmode);
            out_ready = 1'b0;
            send(vt[i].ct);
            wait_all_ov(60);
            for (int g = 0; g < NI; g++)
                chk($sformatf("table%0d[g%0d]", i, g), out_data[g], vt[i].pt);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // Random golden comparison
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (i % 50 == 0) begin
                wait_idle(200);
                set_keys(3);
            end
            send(rand128());
        end
        wait_idle(200);

        // Backpressure in DONE
        out_ready = 1'b0;
        send(rand128());
        n = 0;
        while (!out_valid[0] && n < 60) begin
            tick();
            n++;
        end
        chk("bp_reach_done", 128'(out_valid[0]), 128'(1));
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            in_data  = rand128();
            tick();
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_in_ready", 128'(in_ready), 128'({NI{1'b1}}));

        // Reset on the 10th RUN cycle
        send(rand128());
        for (int c = 0; c < 9; c++) tick();
        chk("pre_reset_busy0", 128'(busy[0]), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int g = 0; g < NI; g++) begin
            chk("mrst_in_ready",  128'(in_ready[g]),  128'(1));
            chk("mrst_busy",      128'(busy[g]),      128'(0));
            chk("mrst_out_valid", 128'(out_valid[g]), 128'(0));
            chk("mrst_rk_idx",    128'(rk_idx[g]),    128'(31));
        end
        any_ov = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            any_ov = any_ov | (|out_valid);
        end
        chk("mrst_no_out_valid", 128'(any_ov), 128'(0));
        out_ready = 1'b1;
        send(rand128());
        wait_idle(200);

        // Back-to-back streaming
        stream_on    = 1'b1;
        stream_start = cyc;
        base         = acc_cnt[1];
        in_valid     = 1'b1;
        n = 0;
        while (acc_cnt[1] - base < 10 && n < 400) begin
            in_data = rand128();
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("stream_count_r2", 128'(acc_cnt[1] - base), 128'(10));
        wait_idle(200);
        stream_on = 1'b0;
        for (int g = 0; g < NI; g++)
            chk($sformatf("drained[g%0d]", g), 128'(exp_q[g].size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serpent_dec_iter.md
# serpent_dec_iter

Iterative, parametrised Serpent-128 decryption core. It replaces a fixed 32-stage unrolled chain of decryption rounds with a single datapath of `RPC` round stages that is reused across `32/RPC` cycles. A valid/ready handshake sits on both the ciphertext input and the plaintext output. Round keys come from an external key store through a same-cycle read port indexed by the core.

## Interface
Parameters:
- `RPC`, default 1: rounds applied per clock.
  - Legal values are 1, 2, 4, 8.
  - Any other value is a compile-time error.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: `in_data` holds a ciphertext block.
- `in_ready` output 1: core can accept a block.
- `in_data` input 128: ciphertext; word x0 = [31:0], x1 = [63:32], x2 = [95:64], x3 = [127:96].
- `out_valid` output 1: `out_data` holds a plaintext block.
- `out_ready` input 1: downstream accepts the plaintext.
- `out_data` output 128: plaintext, same word layout as `in_data`.
- `rk_idx` output 6: highest round-key index needed this cycle.
- `rk_data` input 128*RPC: combinational key read; slice j (bits [128j+127:128j]) = K[rk_idx − j].
- `rk_last` input 128: K32, stable for the whole run.
- `busy` output 1: high in RUN.

## Operation
- **FSM states:** IDLE, RUN, DONE. Round counter `r` is 6 bits; state register `S` is 128 bits.
- **IDLE:**
  - `in_ready`=1, `r`=31.
  - On `in_valid`&`in_ready`: `S`←`in_data`, go to RUN.
- **RUN:** each cycle applies RPC rounds in slices j=0..RPC−1, round index k=r−j.
  - **k=31** (slice 0 of the first cycle only): t = invS7(S ⊕ `rk_last`) ⊕ K31.
  - **k<31:** t = invS(k mod 8)(invLT(S)) ⊕ K_k.
  - The output of slice j feeds slice j+1. `S`←output of the last slice.
  - If r = RPC−1, go to DONE; else r←r−RPC.
- **invLT, on words x0..x3, in this order:**
  - x2=ror(x2,22); x0=ror(x0,5)
  - x2^=x3^(x1<<7); x0^=x1^x3
  - x3=ror(x3,7); x1=ror(x1,1)
  - x3^=x2^(x0<<3); x1^=x0^x2
  - x2=ror(x2,3); x0=ror(x0,13)
  - Shifts are logical 32-bit; ror is a 32-bit rotate right.
- **Inverse S-box layer:** bitsliced, combinational. It may reuse the existing inv_S0_32..inv_S7_32 (their clk is tied, with no register inside). For RPC<8 each slice muxes the box by k mod 8.
- **DONE:**
  - `out_valid`=1, `out_data`=`S`, held stable.
  - On `out_ready`: go to IDLE, r←31.
- `in_valid` outside IDLE is ignored; no data is captured.
- `rk_idx` = `r` at all times. It therefore shows 31 in IDLE so the key store can present K31..K(32−RPC) in advance.

## Timing
- **Reset values:** FSM=IDLE, `r`=31, `S`=0. Outputs: `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0, `rk_idx`=31.
- **Reset mid-RUN or mid-DONE:** the block returns to IDLE on that edge and the in-flight block is discarded. No `out_valid` pulse follows.
- **Latency:** the accept edge is E0. RUN spans edges E1..E(32/RPC). `out_valid` is first high in the cycle after E(32/RPC). That gives 32 cycles at RPC=1 and 4 at RPC=8.
- **`rk_idx` sequence in RUN:** 31, 31−RPC, …, RPC−1. Key data is sampled in the same cycle, with no key-read latency.
- **Handshakes:**
  - Input transfer = `in_valid`&`in_ready` at an edge.
  - Output transfer = `out_valid`&`out_ready` at an edge.
  - `in_ready` rises the cycle after the output transfer; there is no same-cycle turnaround.
- **Throughput:** one block per 32/RPC + 2 cycles with `out_ready` held high.
- **Backpressure:** `out_data` and `out_valid` are held indefinitely while `out_ready`=0.
- **Critical path:** RPC × (invLT + S-box + XOR). Only `S`, `r` and the FSM are registered.

## Test plan
- **Golden match, RPC=1:**
  - Stimulus: random keys K0..K32 and 200 random ciphertexts.
  - Required: `out_data` equals the golden model (unrolled K32-XOR/invS7/K31 followed by rounds 30..0). `out_valid` rises exactly 32 cycles after each accept.
- **Key index sequencing:**
  - Stimulus: RPC=4, ct=128'h0, all keys 0.
  - Required: `rk_idx` reads 31,27,23,19,15,11,7,3 over RUN. Output matches the model. Latency is 8 cycles.
- **Backpressure:**
  - Stimulus: hold `out_ready`=0 for 5 cycles in DONE.
  - Required: `out_data` stays constant, `in_ready`=0, and `in_valid` pulses are ignored. After `out_ready`=1, `in_ready`=1 on the next cycle.
- **Mid-run reset:**
  - Stimulus: `rst`=1 on the 10th RUN cycle.
  - Required: the next cycle shows `in_ready`=1, `busy`=0, `out_valid`=0, `rk_idx`=31. A new block then decrypts correctly.
- **Parameter sweep:**
  - Stimulus: RPC ∈ {1, 2, 4, 8} with identical vectors.
  - Required: plaintexts are identical across all four. Latency is 32, 16, 8, 4 respectively.
- **Back-to-back streaming:**
  - Stimulus: `in_valid` and `out_ready` held high, 10 blocks, RPC=2.
  - Required: a new block is accepted every 18 cycles. Outputs come out in order and all are correct.
